// File: rtl/subword_access_unit_pkg.sv
// mem_access_pkg: access sizes, RMW states and lane count shared by the subword access unit
package mem_access_pkg;
  typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_RSVD} mem_size_t;
  typedef enum logic [1:0] {IDLE, RMW_READ, RMW_WRITE} mem_state_t;
  localparam int BYTE_LANES = 4;
endpackage

// File: rtl/subword_access_unit_if.sv
// subword_access_unit_if: CPU-side and memory-side bus of the subword access unit
interface subword_access_unit_if
  import mem_access_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic            req;
  logic            write;
  mem_size_t       size;
  logic            sign_ext;
  logic [AW-1:0]   addr;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic            addr_error;
  logic [AW-1:0]   mem_addr;
  logic            mem_write;
  logic [DW-1:0]   mem_din;
  logic [DW-1:0]   mem_dout;
  logic            mem_busy;
  modport master (
    output req, write, size, sign_ext, addr, wdata, mem_dout, mem_busy,
    input  rdata, busy, addr_error, mem_addr, mem_write, mem_din
  );
  modport slave (
    input  req, write, size, sign_ext, addr, wdata, mem_dout, mem_busy,
    output rdata, busy, addr_error, mem_addr, mem_write, mem_din
  );
endinterface

// File: rtl/subword_access_unit_merge.sv
// store_lane_merge: replaces the addressed byte/halfword lane of old_word with store data
module store_lane_merge
  import mem_access_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  input  mem_size_t   size,
  input  logic [1:0]  lane,
  output logic [31:0] merged
);
  logic [31:0] mask, data;
  always_comb begin
    mask = size == SIZE_BYTE ? 32'h0000_00ff << {lane, 3'b000} :
           size == SIZE_HALF ? 32'h0000_ffff << {lane[1], 4'b0000} : '1;
    data = size == SIZE_BYTE ? {BYTE_LANES{wdata[7:0]}} :
           size == SIZE_HALF ? {2{wdata[15:0]}} : wdata;
    merged = (old_word & ~mask) | (data & mask);
  end
endmodule

// File: rtl/subword_access_unit.sv
// subword_access_unit: byte/half/word CPU accesses onto word-only memory; MISALIGN_TRAP_EN enables addr_error
module subword_access_unit
  import mem_access_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic clk,
  input logic reset,
  subword_access_unit_if.slave bus
);
  mem_state_t    state;
  logic [DW-1:0] merge_q, merged, ext;
  logic [7:0]    b;
  logic [15:0]   h;
  logic          idle_req, err, sub_st;
  assign idle_req = state == IDLE && bus.req && !reset;
`ifdef MISALIGN_TRAP_EN
  assign err = idle_req && (bus.size == SIZE_RSVD ||
                            (bus.size == SIZE_HALF && bus.addr[0]) ||
                            (bus.size == SIZE_WORD && bus.addr[1:0] != 2'b00));
`else
  assign err = 1'b0;
`endif
  // size[1] set means word access; reserved size only reaches here as a word when untrapped
  assign sub_st = idle_req && bus.write && !bus.size[1] && !err;
  store_lane_merge u_merge (
    .old_word(bus.mem_dout),
    .wdata   (bus.wdata),
    .size    (bus.size),
    .lane    (bus.addr[1:0]),
    .merged  (merged)
  );
  always_comb begin
    b = bus.mem_dout[{bus.addr[1:0], 3'b000} +: 8];
    h = bus.mem_dout[{bus.addr[1], 4'b0000} +: 16];
    ext = bus.size == SIZE_BYTE ? {{24{bus.sign_ext & b[7]}}, b} :
          bus.size == SIZE_HALF ? {{16{bus.sign_ext & h[15]}}, h} : bus.mem_dout;
    bus.rdata = idle_req && !bus.write && !err ? ext : '0;
    bus.addr_error = err;
    bus.mem_addr = {bus.addr[AW-1:2], 2'b00};
    bus.mem_din = state == RMW_WRITE ? merge_q : bus.wdata;
    bus.mem_write = !reset && (state == RMW_WRITE || (idle_req && bus.write && bus.size[1] && !err));
    bus.busy = !reset && (state == RMW_READ || (state == RMW_WRITE && bus.mem_busy) ||
                          (idle_req && !err && (sub_st || bus.mem_busy)));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      merge_q <= '0;
    end else begin
      unique case (state)
        IDLE: if (sub_st) state <= RMW_READ;
        RMW_READ:
          if (!bus.req) state <= IDLE;
          else if (!bus.mem_busy) begin
            merge_q <= merged;
            state <= RMW_WRITE;
          end
        RMW_WRITE: if (!bus.mem_busy) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_subword_access_unit.sv
// tb_subword_access_unit: directed checks of loads, word stores and read-modify-write subword stores
module tb_subword_access_unit;
  import mem_access_pkg::*;
  logic clk = 0;
  logic reset = 1;
  int errors = 0, checks = 0, nwr = 0, wr0;
  logic [31:0] last_din = '0;
  subword_access_unit_if #(.AW(32), .DW(32)) bus ();
  subword_access_unit dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (bus.mem_write) begin
    nwr <= nwr + 1;
    last_din <= bus.mem_din;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic r, input logic w, input mem_size_t s, input logic [31:0] a,
                       input logic [31:0] d, input logic se);
    bus.req = r; bus.write = w; bus.size = s; bus.addr = a; bus.wdata = d; bus.sign_ext = se;
  endtask
  task automatic mid; @(negedge clk); endtask
  task automatic next; @(posedge clk); #1; endtask
  initial begin
    drive(0, 0, SIZE_WORD, 32'h0, 32'h0, 0);
    bus.mem_dout = 32'h80FF_1234; bus.mem_busy = 0;
    mid;
    chk("rst_busy", {31'b0, bus.busy}, 0);
    chk("rst_mem_write", {31'b0, bus.mem_write}, 0);
    chk("rst_addr_error", {31'b0, bus.addr_error}, 0);
    chk("rst_rdata", bus.rdata, 0);
    next; next; reset = 0;
    drive(1, 0, SIZE_BYTE, 32'h1000_0003, 32'h0, 1); mid;
    chk("ldb3_sx", bus.rdata, 32'hFFFF_FF80);
    chk("ldb3_busy", {31'b0, bus.busy}, 0);
    chk("ldb3_mem_addr", bus.mem_addr, 32'h1000_0000);
    chk("ldb3_mem_write", {31'b0, bus.mem_write}, 0);
    bus.sign_ext = 0; mid;
    chk("ldb3_zx", bus.rdata, 32'h0000_0080);
    drive(1, 0, SIZE_BYTE, 32'h1000_0001, 32'h0, 1); mid;
    chk("ldb1_sx", bus.rdata, 32'h0000_0012);
    drive(1, 0, SIZE_HALF, 32'h1000_0002, 32'h0, 1); mid;
    chk("ldh1_sx", bus.rdata, 32'hFFFF_80FF);
    drive(1, 0, SIZE_WORD, 32'h1000_0000, 32'h0, 0); bus.mem_busy = 1; mid;
    chk("ldw", bus.rdata, 32'h80FF_1234);
    chk("ldw_stall_busy", {31'b0, bus.busy}, 1);
    bus.mem_busy = 0; next;
    // halfword store with two-cycle RMW
    wr0 = nwr; bus.mem_dout = 32'h1122_3344;
    drive(1, 1, SIZE_HALF, 32'h1000_0006, 32'h0000_BEEF, 0); mid;
    chk("sh_c0_busy", {31'b0, bus.busy}, 1);
    chk("sh_c0_wr", {31'b0, bus.mem_write}, 0);
    chk("sh_c0_rdata", bus.rdata, 0);
    next; mid;
    chk("sh_c1_busy", {31'b0, bus.busy}, 1);
    chk("sh_c1_wr", {31'b0, bus.mem_write}, 0);
    next; mid;
    chk("sh_c2_busy", {31'b0, bus.busy}, 0);
    chk("sh_c2_wr", {31'b0, bus.mem_write}, 1);
    chk("sh_c2_din", bus.mem_din, 32'hBEEF_3344);
    chk("sh_c2_addr", bus.mem_addr, 32'h1000_0004);
    next; bus.req = 0; next;
    chk("sh_writes", nwr - wr0, 1);
    chk("sh_last_din", last_din, 32'hBEEF_3344);
    // byte store with memory stall in RMW_READ
    wr0 = nwr;
    drive(1, 1, SIZE_BYTE, 32'h0000_0041, 32'h0000_00AA, 0); mid;
    chk("sb_c0_busy", {31'b0, bus.busy}, 1);
    next; bus.mem_busy = 1; mid;
    chk("sb_stall1_busy", {31'b0, bus.busy}, 1);
    chk("sb_stall1_wr", {31'b0, bus.mem_write}, 0);
    next; mid;
    chk("sb_stall2_wr", {31'b0, bus.mem_write}, 0);
    next; bus.mem_busy = 0; mid;
    chk("sb_read_busy", {31'b0, bus.busy}, 1);
    chk("sb_read_wr", {31'b0, bus.mem_write}, 0);
    next; mid;
    chk("sb_write_wr", {31'b0, bus.mem_write}, 1);
    chk("sb_write_busy", {31'b0, bus.busy}, 0);
    chk("sb_write_din", bus.mem_din, 32'h1122_AA44);
    next; bus.req = 0; next; next;
    chk("sb_writes", nwr - wr0, 1);
    // word store passes straight through
    wr0 = nwr;
    drive(1, 1, SIZE_WORD, 32'h0000_0020, 32'hDEAD_BEEF, 0); mid;
    chk("sw_wr", {31'b0, bus.mem_write}, 1);
    chk("sw_busy", {31'b0, bus.busy}, 0);
    chk("sw_din", bus.mem_din, 32'hDEAD_BEEF);
    chk("sw_rdata", bus.rdata, 0);
    next; bus.req = 0; mid;
    chk("sw_idle_wr", {31'b0, bus.mem_write}, 0);
    chk("sw_idle_busy", {31'b0, bus.busy}, 0);
    next;
    chk("sw_writes", nwr - wr0, 1);
    // misaligned halfword load and reserved size
    wr0 = nwr; bus.mem_dout = 32'h80FF_1234;
    drive(1, 0, SIZE_HALF, 32'h0000_0001, 32'h0, 0); mid;
`ifdef MISALIGN_TRAP_EN
    chk("mh_err", {31'b0, bus.addr_error}, 1);
    chk("mh_rdata", bus.rdata, 0);
    chk("mh_busy", {31'b0, bus.busy}, 0);
    bus.size = SIZE_RSVD; mid;
    chk("rsvd_err", {31'b0, bus.addr_error}, 1);
    chk("rsvd_rdata", bus.rdata, 0);
    drive(1, 1, SIZE_WORD, 32'h0000_0002, 32'h5555_5555, 0); mid;
    chk("mw_err", {31'b0, bus.addr_error}, 1);
    chk("mw_wr", {31'b0, bus.mem_write}, 0);
`else
    chk("mh_err", {31'b0, bus.addr_error}, 0);
    chk("mh_rdata", bus.rdata, 32'h0000_1234);
    bus.size = SIZE_RSVD; mid;
    chk("rsvd_err", {31'b0, bus.addr_error}, 0);
    chk("rsvd_rdata", bus.rdata, 32'h80FF_1234);
`endif
    next; bus.req = 0; next;
    chk("err_writes", nwr - wr0, 0);
    // abort by dropping req in RMW_READ
    wr0 = nwr;
    drive(1, 1, SIZE_BYTE, 32'h0000_0010, 32'h0000_0077, 0); next;
    bus.req = 0; mid;
    chk("abort_rd_wr", {31'b0, bus.mem_write}, 0);
    next; mid;
    chk("abort_busy", {31'b0, bus.busy}, 0);
    next; next;
    chk("abort_writes", nwr - wr0, 0);
    // reset in RMW_READ
    wr0 = nwr;
    drive(1, 1, SIZE_BYTE, 32'h0000_0012, 32'h0000_0066, 0); next;
    reset = 1; bus.req = 0; mid;
    chk("rstmid_wr", {31'b0, bus.mem_write}, 0);
    next; reset = 0; mid;
    chk("rstmid_busy", {31'b0, bus.busy}, 0);
    chk("rstmid_wr2", {31'b0, bus.mem_write}, 0);
    next; next; next;
    chk("rstmid_writes", nwr - wr0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
